// File: rtl/riscv_pkg.sv
// Shared RV32I memory-access encodings and load/store unit state type.
package riscv_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_ctrl_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    function automatic logic ctrl_legal(input logic [2:0] c);
        return (c == MEM_B) || (c == MEM_H) || (c == MEM_W) ||
               (c == MEM_BU) || (c == MEM_HU);
    endfunction

    // Low two funct3 bits encode the access size for every legal code.
    function automatic logic ctrl_misaligned(input logic [2:0] c, input logic [1:0] off);
        return ((c[1:0] == 2'b01) && off[0]) || ((c[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane enables, store data replication and load extraction/extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  mem_ctrl_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_ext_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (mem_ctrl_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (mem_ctrl_i)
            MEM_B:   load_ext_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_H:   load_ext_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_W:   load_ext_o = shifted;
            MEM_BU:  load_ext_o = {24'b0, shifted[7:0]};
            MEM_HU:  load_ext_o = {16'b0, shifted[15:0]};
            default: load_ext_o = 32'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core memory request into a req/gnt + rvalid bus
// transaction, stalling the core until the access completes.
module load_store_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memR,
    input  logic        memW,
    input  logic [2:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_q, load_d;
    logic        fault_q, fault_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [1:0]  off_q, off_d;

    logic [2:0]  align_ctrl;
    logic [1:0]  align_off;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        access;
    logic        bad_access;

    // In IDLE the live request drives lane generation; afterwards the latched copy does.
    assign align_ctrl = (state_q == LSU_IDLE) ? mem_ctrl  : ctrl_q;
    assign align_off  = (state_q == LSU_IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .mem_ctrl_i  (align_ctrl),
        .offset_i    (align_off),
        .store_data_i(store_data),
        .rdata_i     (bus_rdata),
        .be_o        (align_be),
        .wdata_o     (align_wdata),
        .load_ext_o  (align_load)
    );

    assign access     = memR | memW;
    assign bad_access = !ctrl_legal(mem_ctrl) || ctrl_misaligned(mem_ctrl, addr[1:0]);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        fault_d = 1'b0;
        ctrl_d  = ctrl_q;
        off_d   = off_q;
        case (state_q)
            LSU_IDLE: begin
                if (access) begin
                    if (bad_access) begin
                        state_d = LSU_DONE;
                        fault_d = 1'b1;
                        load_d  = 32'b0;
                    end else begin
                        state_d = LSU_REQ;
                        req_d   = 1'b1;
                        we_d    = memW;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = align_be;
                        wdata_d = align_wdata;
                        ctrl_d  = mem_ctrl;
                        off_d   = addr[1:0];
                    end
                end
            end
            LSU_REQ: begin
                if (bus_gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (bus_rvalid) begin
                    load_d  = align_load;
                    state_d = LSU_DONE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LSU_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'b0;
            be_q    <= 4'b0;
            wdata_q <= 32'b0;
            load_q  <= 32'b0;
            fault_q <= 1'b0;
            ctrl_q  <= 3'b0;
            off_q   <= 2'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            fault_q <= fault_d;
            ctrl_q  <= ctrl_d;
            off_q   <= off_d;
        end
    end

    assign stall     = ((state_q == LSU_IDLE) && access) ||
                       (state_q == LSU_REQ) || (state_q == LSU_WAIT);
    assign load_data = load_q;
    assign fault     = fault_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a transaction-level model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        memR, memW;
    logic [2:0]  mem_ctrl;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, fault;
    logic        bus_req, bus_gnt, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int compared   = 0;
    int mismatched = 0;

    logic        checkEn = 1'b0;
    logic        expStall, expReq, expFault, expWe;
    logic [31:0] expLoad, expAddr, expWdata;
    logic [3:0]  expBe;
    logic [3:0]  capBe;
    logic [31:0] capAddr, capWdata;
    logic        capWe;

    load_store_unit dut (
        .clk(clk), .reset(reset), .memR(memR), .memW(memW), .mem_ctrl(mem_ctrl),
        .addr(addr), .store_data(store_data), .load_data(load_data), .stall(stall),
        .fault(fault), .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sizeOf(input logic [2:0] c);
        case (c[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legalCtrl(input logic [2:0] c);
        return c inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic bit faulty(input logic [2:0] c, input logic [31:0] a);
        return !legalCtrl(c) || ((a % sizeOf(c)) != 0);
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] c, input logic [31:0] a);
        logic [7:0] m;
        m = 8'(((1 << sizeOf(c)) - 1) << (a % 4));
        return m[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] c, input logic [31:0] sd);
        case (sizeOf(c))
            1:       return {4{sd[7:0]}};
            2:       return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] c, input logic [31:0] a,
                                              input logic [31:0] rd);
        int unsigned v;
        v = rd >> (8 * (a % 4));
        if (sizeOf(c) == 1) begin
            v = v % 256;
            if (!c[2] && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sizeOf(c) == 2) begin
            v = v % 65536;
            if (!c[2] && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
            checkOutput("bus_req", {31'b0, bus_req}, {31'b0, expReq});
            checkOutput("fault", {31'b0, fault}, {31'b0, expFault});
            checkOutput("load_data", load_data, expLoad);
            if (expReq) begin
                checkOutput("bus_we", {31'b0, bus_we}, {31'b0, expWe});
                checkOutput("bus_addr", bus_addr, expAddr);
                checkOutput("bus_be", {28'b0, bus_be}, {28'b0, expBe});
                if (expWe) checkOutput("bus_wdata", bus_wdata, expWdata);
            end
        end
    end

    task automatic junkInputs();
        memR = 1'($urandom); memW = 1'($urandom); mem_ctrl = 3'($urandom);
        addr = $urandom; store_data = $urandom;
        bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
        junkInputs();
        memR = 1'b0; memW = 1'b0;
        expStall = 1'b0; expReq = 1'b0; expFault = 1'b0;
    endtask

    // One full core memory instruction; returns during its DONE cycle.
    task automatic applyStimulus(input logic r, input logic w, input logic [2:0] c,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input int g, input int rv, input logic [31:0] rd);
        @(posedge clk); #1;
        memR = r; memW = w; mem_ctrl = c; addr = a; store_data = sd;
        bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
        expStall = 1'b1; expReq = 1'b0; expFault = 1'b0;
        capBe = 4'b0; capAddr = 32'b0; capWdata = 32'b0; capWe = 1'b0;
        if (faulty(c, a)) begin
            @(posedge clk); #1;
            junkInputs();
            expStall = 1'b0; expFault = 1'b1; expLoad = 32'b0;
            return;
        end
        expWe = w; expAddr = {a[31:2], 2'b00}; expBe = modelBe(c, a); expWdata = modelWdata(c, sd);
        for (int i = 0; i <= g; i++) begin
            @(posedge clk); #1;
            bus_gnt = (i == g); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            expReq = 1'b1; expStall = 1'b1;
            if (i == 0) begin
                @(negedge clk);
                capBe = bus_be; capAddr = bus_addr; capWdata = bus_wdata; capWe = bus_we;
            end
        end
        if (!w) begin
            for (int j = 0; j <= rv; j++) begin
                @(posedge clk); #1;
                bus_gnt = 1'($urandom); bus_rvalid = (j == rv);
                bus_rdata = (j == rv) ? rd : $urandom;
                expReq = 1'b0; expStall = 1'b1;
            end
        end
        @(posedge clk); #1;
        junkInputs();
        expReq = 1'b0; expStall = 1'b0;
        if (!w) expLoad = modelLoad(c, a, rd);
    endtask

    initial begin
        logic [2:0] legalList [5];
        logic [2:0] c;
        logic [31:0] a;
        int kind;
        legalList = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        reset = 1'b0; memR = 1'b0; memW = 1'b0; mem_ctrl = 3'b0; addr = 32'b0;
        store_data = 32'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_bus_req", {31'b0, bus_req}, 32'd0);
        checkOutput("rst_bus_we", {31'b0, bus_we}, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_be", {28'b0, bus_be}, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_load_data", load_data, 32'd0);
        checkOutput("rst_fault", {31'b0, fault}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        expStall = 1'b0; expReq = 1'b0; expFault = 1'b0; expLoad = 32'b0; expWe = 1'b0;
        expAddr = 32'b0; expBe = 4'b0; expWdata = 32'b0;
        checkEn = 1'b1;

        applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("lw_lit_data", load_data, 32'hDEADBEEF);
        checkOutput("lw_lit_addr", capAddr, 32'h100);
        checkOutput("lw_lit_be", {28'b0, capBe}, 32'hF);
        applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 1, 2, 32'h80FF0000);
        @(negedge clk);
        checkOutput("lb_lit_data", load_data, 32'hFFFFFF80);
        checkOutput("lb_lit_be", {28'b0, capBe}, 32'h8);
        applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
        @(negedge clk);
        checkOutput("lbu_lit_data", load_data, 32'h00000080);
        applyStimulus(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0, 32'h0);
        @(negedge clk);
        checkOutput("sh_lit_be", {28'b0, capBe}, 32'hC);
        checkOutput("sh_lit_wdata", capWdata, 32'hABCDABCD);
        checkOutput("sh_lit_data_kept", load_data, 32'h00000080);
        applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("lw_mis_fault", {31'b0, fault}, 32'd1);
        checkOutput("lw_mis_zero", load_data, 32'd0);
        applyStimulus(0, 1, 3'b001, 32'h101, 32'h5555, 0, 0, 32'h0);
        applyStimulus(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        idleCycle();
        applyStimulus(1, 1, 3'b010, 32'h10, 32'hA5A5A5A5, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("both_we_lit", {31'b0, capWe}, 32'd1);
        checkOutput("both_addr_lit", capAddr, 32'h10);

        for (int t = 0; t < 300; t++) begin
            if ($urandom % 10 < 8) c = legalList[$urandom % 5];
            else c = 3'($urandom);
            a = $urandom;
            if ($urandom % 4 != 0) a = a & ~(32'(sizeOf(c)) - 32'd1);
            kind = $urandom % 3;
            applyStimulus(kind != 1, kind != 0, c, a, $urandom,
                          $urandom % 4, $urandom % 4, $urandom);
            repeat ($urandom % 2) idleCycle();
        end

        // Reset during WAIT: outputs clear at once and a late rvalid must not land.
        idleCycle();
        checkEn = 1'b0;
        @(posedge clk); #1;
        memR = 1'b1; memW = 1'b0; mem_ctrl = 3'b010; addr = 32'h100;
        bus_gnt = 1'b1; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; memR = 1'b0;
        #2;
        checkOutput("rmid_bus_req", {31'b0, bus_req}, 32'd0);
        checkOutput("rmid_bus_we", {31'b0, bus_we}, 32'd0);
        checkOutput("rmid_bus_addr", bus_addr, 32'd0);
        checkOutput("rmid_bus_be", {28'b0, bus_be}, 32'd0);
        checkOutput("rmid_load_data", load_data, 32'd0);
        checkOutput("rmid_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rlate_load_data", load_data, 32'd0);
            checkOutput("rlate_bus_req", {31'b0, bus_req}, 32'd0);
            checkOutput("rlate_stall", {31'b0, stall}, 32'd0);
        end
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        expLoad = 32'b0; expStall = 1'b0; expReq = 1'b0; expFault = 1'b0;
        checkEn = 1'b1;
        idleCycle();
        @(negedge clk);
        checkEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the memory-access stage and the data-memory bus, replacing the direct single-cycle memory hookup. Accepts a load/store request from the core (address, store data, width/sign code), then runs a req/gnt + rvalid bus handshake. Holds the core with `stall` until the access completes. Byte lanes, misalignment and illegal-width faults are resolved here, and sign/zero-extended load data is returned.

## Interface
Parameters:
- none (widths fixed by RV32I: 32-bit data/address, 4 byte lanes)

Ports:
- `clk` in 1: rising-edge clock
- `reset` in 1: reset, asynchronous, active-low
- `memR` in 1: load request from control unit
- `memW` in 1: store request; wins over `memR` if both high
- `mem_ctrl` in 3: funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- `addr` in 32: byte address (ALU result)
- `store_data` in 32: rs2 value for stores
- `load_data` out 32: extended load result, valid in DONE
- `stall` out 1: core must hold PC and all request inputs while high
- `fault` out 1: one-cycle pulse in DONE for misaligned or illegal access
- `bus_req` out 1: bus request
- `bus_gnt` in 1: request accepted this cycle
- `bus_we` out 1: 1 = write
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`
- `bus_be` out 4: byte enables
- `bus_wdata` out 32: lane-replicated store data
- `bus_rvalid` in 1: read data valid
- `bus_rdata` in 32: read data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `memR|memW` with legal, aligned access: latch `we`, `mem_ctrl`, `addr[1:0]`, and bus fields; go to REQ.
  - Misaligned (H with `addr[0]`, W with `addr[1:0]!=0`) or illegal `mem_ctrl`: no bus activity; go to DONE with `fault`=1.
- **REQ:** `bus_req`=1 with all bus outputs held stable until `bus_gnt`.
  - On gnt, a store goes to DONE.
  - On gnt, a load goes to WAIT.
- **WAIT:** on `bus_rvalid`, register the extracted load data and go to DONE.
- **DONE:** the core advances this cycle, and request inputs are ignored. Next state is always IDLE.
- `stall` (combinational) = (IDLE & (`memR|memW`)) | REQ | WAIT. It is 0 in DONE.
- Store lanes:
  - SB: `be`=`4'b0001<<addr[1:0]`, `wdata`=`{4{sd[7:0]}}`.
  - SH: `be`=`4'b0011<<addr[1:0]`, `wdata`=`{2{sd[15:0]}}`.
  - SW: `be`=1111.
- Loads: `bus_be` from the same rule and `bus_we`=0.
- Load extraction:
  - `sh = bus_rdata >> (8*addr[1:0])`.
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- `load_data` holds its value until the next load completes. It is forced to 0 on a faulting access and is unchanged after a store.
- `bus_rvalid` outside WAIT is ignored. `bus_gnt` outside REQ is ignored.

## Timing
- Reset (async, `reset`=0): state IDLE.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `load_data`, `fault` = 0.
  - `stall` = 0 with no request present.
- All bus outputs and `load_data`/`fault` are registered; only `stall` is combinational.
- `bus_req` rises the cycle after IDLE accepts a request. It falls the cycle after gnt.
- Best-case load (gnt in first REQ cycle, rvalid the next cycle): request seen at T0, REQ T1, WAIT T2, DONE T3. `stall` high T0–T2.
- Best-case store: REQ T1, DONE T2. `stall` high T0–T1.
- Fault: IDLE T0 (`stall`=1), DONE T1 (`fault`=1).
- Back-to-back memory instructions: one IDLE cycle between DONE and the next REQ, with `bus_req` low for ≥1 cycle.
- Reset mid-operation: immediately IDLE with `bus_req` low. A late `bus_rvalid` is ignored.

## Structure
- Shared package `riscv_pkg`:
  - `mem_ctrl` encodings as a typedef enum: `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`.
  - LSU state enum.
- One sub-module: `lsu_align`, combinational. It provides `be`/`wdata` generation and load extraction/extension, shared by the store and load paths.

## Test plan
- LW, `addr`=0x100, gnt at first REQ cycle, rdata=0xDEADBEEF next cycle -> `bus_addr`=0x100, `be`=1111, `stall` 3 cycles, `load_data`=0xDEADBEEF in DONE.
- LB/LBU, `addr`=0x103, rdata=0x80FF_0000 -> LB gives 0xFFFFFF80, LBU gives 0x00000080, `be`=1000.
- SH, `addr`=0x202, `store_data`=0x1234ABCD, gnt delayed 3 cycles -> `be`=1100, `wdata`=0xABCDABCD, `bus_req` held 4 cycles with outputs stable, `stall` 5 cycles.
- LW at 0x102; SH at 0x101; `mem_ctrl`=011 -> no `bus_req`, `fault`=1 for one cycle, `stall` exactly 1 cycle.
- Both `memR` and `memW`, SW at 0x10 -> write issued (`bus_we`=1).
- Reset asserted in WAIT, then rvalid=1 after release -> `bus_req`=0 and outputs 0 at once, rvalid ignored, `load_data` stays 0.
